// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - five-stage pipeline hazard, forwarding and multi-cycle execute sequencing
module hazard_controller #(
  parameter int MC_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_rs_d,
  input  logic [4:0] i_rt_d,
  input  logic [4:0] i_rs_e,
  input  logic [4:0] i_rt_e,
  input  logic [4:0] i_writereg_e,
  input  logic [4:0] i_writereg_m,
  input  logic [4:0] i_writereg_w,
  input  logic       i_regwrite_e,
  input  logic       i_regwrite_m,
  input  logic       i_regwrite_w,
  input  logic       i_memtoreg_e,
  input  logic       i_memtoreg_m,
  input  logic       i_branch_d,
  input  logic       i_jump_taken_d,
  input  logic       i_mc_start_e,
  output logic       o_stall_f,
  output logic       o_stall_d,
  output logic       o_stall_e,
  output logic       o_flush_d,
  output logic       o_flush_e,
  output logic       o_flush_m,
  output logic [1:0] o_forward_ae,
  output logic [1:0] o_forward_be,
  output logic       o_forward_ad,
  output logic       o_forward_bd,
  output logic       o_mc_busy
);

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MC_CYCLES - 2);

  state_t     r_state;
  logic [3:0] r_cnt;

  logic w_lwstall;
  logic w_brstall;
  logic w_mcstall;
  logic w_stall_d;
  logic w_fwd_a_m, w_fwd_a_w, w_fwd_b_m, w_fwd_b_w;
  logic w_dep_e, w_dep_m;

  // Register 0 is hard-wired zero, so it never takes a forwarded value
  assign w_fwd_a_m = (i_rs_e != 5'd0) && i_regwrite_m && (i_writereg_m == i_rs_e);
  assign w_fwd_a_w = (i_rs_e != 5'd0) && i_regwrite_w && (i_writereg_w == i_rs_e);
  assign w_fwd_b_m = (i_rt_e != 5'd0) && i_regwrite_m && (i_writereg_m == i_rt_e);
  assign w_fwd_b_w = (i_rt_e != 5'd0) && i_regwrite_w && (i_writereg_w == i_rt_e);

  assign o_forward_ae = w_fwd_a_m ? 2'b10 : (w_fwd_a_w ? 2'b01 : 2'b00);
  assign o_forward_be = w_fwd_b_m ? 2'b10 : (w_fwd_b_w ? 2'b01 : 2'b00);

  assign o_forward_ad = (i_rs_d != 5'd0) && i_regwrite_m && (i_writereg_m == i_rs_d);
  assign o_forward_bd = (i_rt_d != 5'd0) && i_regwrite_m && (i_writereg_m == i_rt_d);

  assign w_lwstall = i_memtoreg_e && ((i_rs_d == i_writereg_e) || (i_rt_d == i_writereg_e));

  assign w_dep_e   = i_regwrite_e && ((i_writereg_e == i_rs_d) || (i_writereg_e == i_rt_d));
  assign w_dep_m   = i_memtoreg_m && ((i_writereg_m == i_rs_d) || (i_writereg_m == i_rt_d));
  assign w_brstall = i_branch_d && (w_dep_e || w_dep_m);

  // Reset empties the pipeline, so no multi-cycle hold survives it even if mc_start_e is still high
  assign w_mcstall = i_reset && ((r_state == RUN) ? i_mc_start_e : (r_cnt != 4'd0));

  assign w_stall_d = w_lwstall | w_brstall | w_mcstall;

  assign o_stall_f = w_stall_d;
  assign o_stall_d = w_stall_d;
  assign o_stall_e = w_mcstall;
  assign o_flush_m = w_mcstall;
  assign o_flush_e = (w_lwstall | w_brstall) & ~w_mcstall;
  assign o_flush_d = i_jump_taken_d & ~w_stall_d;
  assign o_mc_busy = (r_state == MC_BUSY);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_mc_start_e) begin
            r_state <= MC_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        MC_BUSY: begin
          // mc_start_e is still asserted by the held instruction and is ignored here
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - table-driven scoreboard bench for hazard_controller
module tb_hazard_controller;

  logic       clk;
  logic       i_reset;
  logic [4:0] i_rs_d, i_rt_d, i_rs_e, i_rt_e;
  logic [4:0] i_writereg_e, i_writereg_m, i_writereg_w;
  logic       i_regwrite_e, i_regwrite_m, i_regwrite_w;
  logic       i_memtoreg_e, i_memtoreg_m;
  logic       i_branch_d, i_jump_taken_d, i_mc_start_e;
  logic       o_stall_f, o_stall_d, o_stall_e, o_flush_d, o_flush_e, o_flush_m;
  logic [1:0] o_forward_ae, o_forward_be;
  logic       o_forward_ad, o_forward_bd, o_mc_busy;

  hazard_controller #(.MC_CYCLES(4)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_rs_d        (i_rs_d),
    .i_rt_d        (i_rt_d),
    .i_rs_e        (i_rs_e),
    .i_rt_e        (i_rt_e),
    .i_writereg_e  (i_writereg_e),
    .i_writereg_m  (i_writereg_m),
    .i_writereg_w  (i_writereg_w),
    .i_regwrite_e  (i_regwrite_e),
    .i_regwrite_m  (i_regwrite_m),
    .i_regwrite_w  (i_regwrite_w),
    .i_memtoreg_e  (i_memtoreg_e),
    .i_memtoreg_m  (i_memtoreg_m),
    .i_branch_d    (i_branch_d),
    .i_jump_taken_d(i_jump_taken_d),
    .i_mc_start_e  (i_mc_start_e),
    .o_stall_f     (o_stall_f),
    .o_stall_d     (o_stall_d),
    .o_stall_e     (o_stall_e),
    .o_flush_d     (o_flush_d),
    .o_flush_e     (o_flush_e),
    .o_flush_m     (o_flush_m),
    .o_forward_ae  (o_forward_ae),
    .o_forward_be  (o_forward_be),
    .o_forward_ad  (o_forward_ad),
    .o_forward_bd  (o_forward_bd),
    .o_mc_busy     (o_mc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, branch, jump, mc;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic [12:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [12:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Field order: stall_f stall_d stall_e flush_d flush_e flush_m fwd_ae fwd_be fwd_ad fwd_bd mc_busy
  function automatic logic [12:0] e(logic sf, logic sd, logic se, logic fd, logic fe, logic fm,
                                    logic [1:0] fa, logic [1:0] fb, logic fad, logic fbd, logic busy);
    return {sf, sd, se, fd, fe, fm, fa, fb, fad, fbd, busy};
  endfunction

  function automatic in_t idle();
    in_t v;
    v.rst = 1'b1;
    v.rs_d = '0; v.rt_d = '0; v.rs_e = '0; v.rt_e = '0;
    v.wr_e = '0; v.wr_m = '0; v.wr_w = '0;
    v.rw_e = 1'b0; v.rw_m = 1'b0; v.rw_w = 1'b0;
    v.m2r_e = 1'b0; v.m2r_m = 1'b0;
    v.branch = 1'b0; v.jump = 1'b0; v.mc = 1'b0;
    return v;
  endfunction

  task automatic add(input string n, input in_t v, input logic [12:0] x);
    vec_t t;
    t.name = n; t.in = v; t.exp = x;
    tbl.push_back(t);
  endtask

  task automatic apply(input in_t v);
    i_reset = v.rst;
    i_rs_d = v.rs_d; i_rt_d = v.rt_d; i_rs_e = v.rs_e; i_rt_e = v.rt_e;
    i_writereg_e = v.wr_e; i_writereg_m = v.wr_m; i_writereg_w = v.wr_w;
    i_regwrite_e = v.rw_e; i_regwrite_m = v.rw_m; i_regwrite_w = v.rw_w;
    i_memtoreg_e = v.m2r_e; i_memtoreg_m = v.m2r_m;
    i_branch_d = v.branch; i_jump_taken_d = v.jump; i_mc_start_e = v.mc;
  endtask

  task automatic check_front();
    sb_t s;
    logic [12:0] got;
    got = {o_stall_f, o_stall_d, o_stall_e, o_flush_d, o_flush_e, o_flush_m,
           o_forward_ae, o_forward_be, o_forward_ad, o_forward_bd, o_mc_busy};
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %b required an expected entry", got);
    end else begin
      s = sb.pop_front();
      if (got !== s.exp) begin
        n_bad++;
        $display("FAIL %s: got %b required %b", s.name, got, s.exp);
      end
    end
  endtask

  initial begin
    in_t  v;
    sb_t  s;

    apply(idle());
    i_reset = 1'b0;

    v = idle(); v.rst = 1'b0;
    add("reset_idle", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,0));
    v = idle();
    add("post_reset_idle", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,0));

    v = idle(); v.rw_m = 1; v.wr_m = 5; v.rw_w = 1; v.wr_w = 5; v.rs_e = 5;
    add("fwd_a_m_priority", v, e(0,0,0,0,0,0,2'b10,2'b00,0,0,0));
    v.wr_m = 6;
    add("fwd_a_w", v, e(0,0,0,0,0,0,2'b01,2'b00,0,0,0));
    v.rs_e = 0;
    add("fwd_a_r0", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,0));
    v = idle(); v.rw_m = 1; v.wr_m = 5; v.rt_e = 5; v.rs_e = 6; v.rw_w = 1; v.wr_w = 6;
    add("fwd_b_m_a_w", v, e(0,0,0,0,0,0,2'b01,2'b10,0,0,0));
    v = idle(); v.rw_m = 1; v.wr_m = 0; v.rw_w = 1; v.wr_w = 0;
    add("fwd_r0_never", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,0));

    v = idle(); v.m2r_e = 1; v.wr_e = 3; v.rt_d = 3; v.jump = 1;
    add("lwstall_jump", v, e(1,1,0,0,1,0,2'b00,2'b00,0,0,0));
    v = idle(); v.m2r_m = 1; v.rw_m = 1; v.wr_m = 3; v.rt_d = 3;
    add("lw_after_bubble", v, e(0,0,0,0,0,0,2'b00,2'b00,0,1,0));
    v = idle(); v.jump = 1;
    add("jump_flush", v, e(0,0,0,1,0,0,2'b00,2'b00,0,0,0));

    v = idle(); v.branch = 1; v.rs_d = 7; v.m2r_m = 1; v.wr_m = 7;
    add("brstall_load_m", v, e(1,1,0,0,1,0,2'b00,2'b00,0,0,0));
    v = idle(); v.branch = 1; v.rs_d = 7; v.rw_m = 1; v.wr_m = 7;
    add("branch_fwd_ad", v, e(0,0,0,0,0,0,2'b00,2'b00,1,0,0));
    v = idle(); v.branch = 1; v.rt_d = 9; v.rw_e = 1; v.wr_e = 9;
    add("brstall_alu_e", v, e(1,1,0,0,1,0,2'b00,2'b00,0,0,0));

    v = idle(); v.mc = 1;
    add("mc_c1", v, e(1,1,1,0,0,1,2'b00,2'b00,0,0,0));
    add("mc_c2", v, e(1,1,1,0,0,1,2'b00,2'b00,0,0,1));
    add("mc_c3", v, e(1,1,1,0,0,1,2'b00,2'b00,0,0,1));
    add("mc_c4_release", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,1));
    v = idle();
    add("mc_c5_run", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,0));

    v = idle(); v.mc = 1; v.m2r_e = 1; v.wr_e = 3; v.rt_d = 3; v.jump = 1;
    add("mc_lw_c1", v, e(1,1,1,0,0,1,2'b00,2'b00,0,0,0));
    v = idle(); v.mc = 1;
    add("mc_lw_c2", v, e(1,1,1,0,0,1,2'b00,2'b00,0,0,1));
    add("mc_lw_c3", v, e(1,1,1,0,0,1,2'b00,2'b00,0,0,1));
    add("mc_lw_c4", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,1));
    v = idle();
    add("mc_lw_c5", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,0));

    v = idle(); v.mc = 1;
    add("mcrst_c1", v, e(1,1,1,0,0,1,2'b00,2'b00,0,0,0));
    add("mcrst_c2", v, e(1,1,1,0,0,1,2'b00,2'b00,0,0,1));
    v.rst = 0;
    add("mcrst_reset", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,0));
    v = idle();
    add("mcrst_after", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,0));
    add("mcrst_after2", v, e(0,0,0,0,0,0,2'b00,2'b00,0,0,0));

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk);
      #1;
      apply(tbl[k].in);
      s.name = tbl[k].name;
      s.exp  = tbl[k].exp;
      sb.push_back(s);
      @(negedge clk);
      check_front();
    end

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the five-stage datapath. It watches register addresses and control bits in the decode, execute, memory and writeback stages. It drives the stall, flush and forwarding selects that sequence the fetch, decode and execute stage registers. It also holds a multi-cycle execute operation in the execute stage for a fixed number of cycles with an internal FSM and counter.

## Interface
- MC_CYCLES, 4, total cycles a multi-cycle op occupies execute; legal range 2..16
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset; clears FSM and counter
- rs_d, rt_d  in  5 each  source register numbers in decode
- rs_e, rt_e  in  5 each  source register numbers in execute
- writereg_e, writereg_m, writereg_w  in  5 each  destination register per stage
- regwrite_e, regwrite_m, regwrite_w  in  1 each  stage writes register file
- memtoreg_e, memtoreg_m  in  1 each  stage instruction is a load
- branch_d  in  1  branch in decode
- jump_taken_d  in  1  jump or taken branch resolved in decode
- mc_start_e  in  1  a multi-cycle op is in execute
- stall_f, stall_d  out  1 each  hold fetch PC and the decode register
- stall_e  out  1  hold the execute register
- flush_d  out  1  synchronous clear of the decode register
- flush_e  out  1  drives the execute register clr (inserts a bubble)
- flush_m  out  1  clear of the memory register (inserts a bubble)
- forward_ae, forward_be  out  2 each  ALU operand selects: 00 = regfile, 10 = M result, 01 = W result
- forward_ad, forward_bd  out  1 each  decode comparator takes the M result
- mc_busy  out  1  FSM is in MC_BUSY

## Operation
- **Forwarding** (combinational), for operand A (B is identical, using rt_e):
  - forward_ae = 10 if rs_e != 0 && regwrite_m && writereg_m == rs_e.
  - Otherwise forward_ae = 01 if rs_e != 0 && regwrite_w && writereg_w == rs_e.
  - Otherwise forward_ae = 00. M has priority over W.
- **Decode forwarding:** forward_ad = rs_d != 0 && regwrite_m && writereg_m == rs_d. forward_bd is the same, using rt_d.
- **Load-use hazard:** lwstall = memtoreg_e && (rs_d == writereg_e || rt_d == writereg_e).
- **Branch hazard:** brstall = branch_d && ((regwrite_e && writereg_e ∈ {rs_d, rt_d}) || (memtoreg_m && writereg_m ∈ {rs_d, rt_d})).
- **FSM states:** RUN, MC_BUSY.
  - RUN, mc_start_e = 1: mcstall = 1, go to MC_BUSY, load cnt = MC_CYCLES-2.
  - MC_BUSY, cnt != 0: mcstall = 1, cnt decrements.
  - MC_BUSY, cnt == 0: mcstall = 0, go to RUN.
  - mc_start_e is ignored in MC_BUSY, because the held instruction keeps asserting it.
- **Output equations:**
  - stall_f = stall_d = lwstall | brstall | mcstall
  - stall_e = mcstall
  - flush_m = mcstall
  - flush_e = (lwstall | brstall) & ~mcstall. While execute is held it is never cleared.
  - flush_d = jump_taken_d & ~stall_d
- **Counter:** cnt is 4 bits wide. It never wraps because it is only decremented when non-zero.
- mc_busy = (state == MC_BUSY).

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and the registered state; there is zero-cycle latency.
- State and cnt update on the rising edge of clk.
- Reset asserted: state = RUN and cnt = 0 immediately.
  - With all inputs 0, every output is 0 (forward selects 00).
- Reset asserted mid multi-cycle op: FSM returns to RUN at once, and stall_e / flush_m drop combinationally.
- A multi-cycle op stays in execute for exactly MC_CYCLES cycles, with MC_CYCLES-1 stalled cycles.
  - The release cycle has mcstall = 0.
  - The next cycle is RUN, with the following instruction in execute.
- A load-use stall lasts 1 cycle: after the bubble, the load is in M and forwarding covers the dependency.
- Simultaneous jump_taken_d and stall_d: flush_d = 0 (the stall wins), so the jump resolves after the stall.
- Simultaneous lwstall and mcstall: stall_e = 1 and flush_e = 0.
- Register 0 never forwards, whatever the regwrite/writereg values.

## Test plan
- Reset low, all inputs 0 -> all outputs 0. Release reset -> outputs still 0, mc_busy = 0.
- regwrite_m = 1, writereg_m = 5, regwrite_w = 1, writereg_w = 5, rs_e = 5 -> forward_ae = 10. Then writereg_m = 6 -> forward_ae = 01. Then rs_e = 0 -> 00.
- memtoreg_e = 1, writereg_e = 3, rt_d = 3 -> stall_f = stall_d = flush_e = 1 for one cycle, stall_e = 0, flush_d = 0 even with jump_taken_d = 1.
- MC_CYCLES = 4, mc_start_e held high for 4 cycles -> stall_e and flush_m high for 3 cycles, mc_busy high in cycles 2-4, all stalls low in cycle 4, state RUN in cycle 5.
- Same op, reset pulsed low during cycle 2 -> stall_e = 0 and mc_busy = 0 immediately. With mc_start_e = 0 after reset, no stall.
- branch_d = 1, rs_d = 7, memtoreg_m = 1, writereg_m = 7 -> brstall: stall_d = 1, flush_e = 1. Next cycle with regwrite_m = 1, memtoreg_m = 0 -> forward_ad = 1, no stall.
